reg_writeback_queue: RTL and testbench

REG_WRITEBACK_QUEUE -- requirements
Module: reg_writeback_queue

---
 rtl/reg_writeback_queue_pkg.sv | 26 ++
 rtl/wbq_fwd_match.sv | 33 +++
 rtl/reg_writeback_queue.sv | 86 ++++++++
 tb/tb_reg_writeback_queue.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_queue_pkg.sv
// Shared types and constants for the register writeback queue.
// Occupancy is a pure function of the pending-entry count.
package reg_writeback_queue_pkg;

  localparam int unsigned REG_ADDR_W    = 5;
  localparam int unsigned REG_DATA_W    = 32;
  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    OccEmpty,
    OccActive,
    OccFull
  } occ_e;

  function automatic occ_e occ_of(input int unsigned cnt, input int unsigned depth);
    if (cnt == 0) return OccEmpty;
    if (cnt >= depth) return OccFull;
    return OccActive;
  endfunction

endpackage

// File: rtl/wbq_fwd_match.sv
// Youngest-match forwarding lookup across all pending writeback entries.
module wbq_fwd_match
  import reg_writeback_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  wb_entry_t [DEPTH-1:0]         entries,
  input  logic      [DEPTH-1:0]         valid,
  input  logic      [$clog2(DEPTH)-1:0] wr_ptr,
  input  logic      [REG_ADDR_W-1:0]    fwd_addr,
  output logic                          hit,
  output logic      [REG_DATA_W-1:0]    data
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0] idx;

  // Walk oldest slot to youngest so the last match seen is the youngest one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = int'(DEPTH); k >= 1; k--) begin
      idx = wr_ptr - PtrW'(k);
      if (valid[idx] && (entries[idx].addr == fwd_addr) && (fwd_addr != '0)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// In-order register writeback queue with stall hold and youngest-match forwarding.
// Writes to register zero complete the handshake but are dropped.
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [REG_ADDR_W-1:0]    wb_addr,
  input  logic [REG_DATA_W-1:0]    wb_data,
  input  logic                     rf_stall,
  output logic                     rf_wr_en,
  output logic [REG_ADDR_W-1:0]    rf_wr_addr,
  output logic [REG_DATA_W-1:0]    rf_wr_data,
  input  logic [REG_ADDR_W-1:0]    fwd_addr,
  output logic                     fwd_hit,
  output logic [REG_DATA_W-1:0]    fwd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [PtrW-1:0]       age [DEPTH];
  logic [DEPTH-1:0]      valid;
  logic                  push, pop;
  occ_e                  occ;

  assign occ      = occ_of(32'(count_q), DEPTH);
  assign wb_ready = (occ != OccFull);
  assign push     = wb_valid && wb_ready && (wb_addr != '0);
  assign rf_wr_en = (occ != OccEmpty) && !rf_stall;
  assign pop      = rf_wr_en;
  assign count    = count_q;

  assign rf_wr_addr = (occ != OccEmpty) ? mem_q[rd_ptr_q].addr : '0;
  assign rf_wr_data = (occ != OccEmpty) ? mem_q[rd_ptr_q].data : '0;

  // Slot i is live when its distance from the head is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    assign age[i]   = PtrW'(i) - rd_ptr_q;
    assign valid[i] = ({1'b0, age[i]} < count_q);
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    count_d  = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately unreset; validity comes only from pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{addr: wb_addr, data: wb_data};
  end

  wbq_fwd_match #(
    .DEPTH(DEPTH)
  ) u_fwd_match (
    .entries  (mem_q),
    .valid    (valid),
    .wr_ptr   (wr_ptr_q),
    .fwd_addr (fwd_addr),
    .hit      (fwd_hit),
    .data     (fwd_data)
  );

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed and randomized bench for reg_writeback_queue against a queue-based reference model.
module tb_reg_writeback_queue;
  import reg_writeback_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        rf_stall;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  wb_entry_t q[$];

  always #5 clk = ~clk;

  reg_writeback_queue #(
    .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .rf_stall   (rf_stall),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .fwd_addr   (fwd_addr),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
    .count      (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Youngest pending write to a nonzero address wins; {hit, data}.
  function automatic logic [32:0] model_fwd(input logic [4:0] a);
    logic [32:0] r;
    r = '0;
    if (a != 0) begin
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].addr == a) r = {1'b1, q[i].data};
      end
    end
    return r;
  endfunction

  task automatic check_all(input string tag);
    logic [32:0] f;
    logic        busy;
    busy = (q.size() > 0);
    f    = model_fwd(fwd_addr);
    chk({tag, ":count"},   32'(count),      32'(q.size()));
    chk({tag, ":ready"},   32'(wb_ready),   32'(q.size() < DEPTH));
    chk({tag, ":wr_en"},   32'(rf_wr_en),   32'(busy && !rf_stall));
    chk({tag, ":wr_addr"}, 32'(rf_wr_addr), busy ? 32'(q[0].addr) : 32'd0);
    chk({tag, ":wr_data"}, rf_wr_data,      busy ? q[0].data : 32'd0);
    chk({tag, ":fwd_hit"}, 32'(fwd_hit),    32'(f[32]));
    chk({tag, ":fwd_data"}, fwd_data,       f[31:0]);
  endtask

  // Drive one cycle from a negedge, check before the edge, advance the model after it.
  task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                      input logic st, input logic [4:0] fa, input string tag);
    logic      do_push, do_pop;
    wb_entry_t e;
    wb_valid = v;
    wb_addr  = a;
    wb_data  = d;
    rf_stall = st;
    fwd_addr = fa;
    #1;
    check_all(tag);
    do_push = v && (q.size() < DEPTH) && (a != 0);
    do_pop  = (q.size() > 0) && !st;
    @(posedge clk);
    if (do_pop) e = q.pop_front();
    if (do_push) q.push_back('{addr: a, data: d});
    @(negedge clk);
  endtask

  initial begin
    logic [4:0]  ra;
    logic [31:0] rd;

    reset    = 1'b0;
    wb_valid = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    rf_stall = 1'b0;
    fwd_addr = '0;
    #1;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Single write, accepted on the first edge after reset release.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, "single_push");
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, "single_write");
    chk("single_done_count", 32'(count), 32'd0);

    // Fill under stall, try a blocked push, then drain in order.
    for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 32'h100 + i, 1'b1, 5'd3, "fill");
    chk("full_ready", 32'(wb_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    step(1'b1, 5'd9, 32'h999, 1'b1, 5'd9, "blocked_push");
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd4, "drain");
    end
    chk("drained_count", 32'(count), 32'd0);

    // Register zero is dropped.
    step(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, "zero_push");
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, "zero_after");
    chk("zero_no_wr", 32'(rf_wr_en), 32'd0);

    // Youngest of two same-address entries is forwarded.
    step(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, "fwd_a");
    step(1'b1, 5'd7, 32'hB, 1'b1, 5'd7, "fwd_b");
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, "fwd_look");
    chk("fwd_prio_hit", 32'(fwd_hit), 32'd1);
    chk("fwd_prio_data", fwd_data, 32'hB);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, "fwd_drain");
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, "fwd_drain");

    // Reset between edges with three stalled entries pending.
    for (int i = 1; i <= 3; i++) step(1'b1, 5'(i + 10), 32'hC0 + i, 1'b1, 5'd0, "pre_rst");
    #2;
    rf_stall = 1'b0;
    reset    = 1'b0;
    #1;
    q.delete();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_wr_en", 32'(rf_wr_en), 32'd0);
    chk("rst_ready", 32'(wb_ready), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_hold_wr_en", 32'(rf_wr_en), 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd11, "post_rst");
    step(1'b1, 5'd11, 32'h55, 1'b0, 5'd11, "post_rst_push");
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd11, "post_rst_wr");

    // Back-to-back push/pop across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      ra = 5'($urandom_range(31, 1));
      rd = $urandom;
      step(1'b1, ra, rd, 1'b0, ra, "wrap");
      chk("wrap_count_le1", 32'(count <= 3'd1), 32'd1);
    end
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, "wrap_drain");

    // Random mix with a narrow address range so forwarding collides often.
    for (int i = 0; i < 150; i++) begin
      step(1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)), $urandom,
           1'($urandom_range(3, 0) == 0 ? 0 : ($urandom_range(1, 0))),
           5'($urandom_range(7, 0)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
